// File: rtl/pe_pkg.sv
// Shared PE definitions: controller state encoding, default data/count widths
// and scratchpad depths used by the PE array and its controller.
package pe_pkg;

    localparam int DATA_SIZE   = 8;
    localparam int CNT_WIDTH   = 8;
    localparam int W_SPAD_NREG = 16;
    localparam int A_SPAD_NREG = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOADW,
        ST_GAPW,
        ST_LOADA,
        ST_GAPA,
        ST_START,
        ST_COMPUTE,
        ST_SUMS,
        ST_DONE
    } pe_state_e;

endpackage

// File: rtl/pe_ctrl_hscnt.sv
// Loadable down-counter with a zero flag; tracks remaining handshakes or
// remaining SUMS cycles.
module pe_ctrl_hscnt
    import pe_pkg::*;
#(
    parameter int W = CNT_WIDTH
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pe_ctrl.sv
// PE job sequencer: validates a job, streams weights then activations into the
// PE, pulses start, waits for completion, then drives the partial-sum phase.
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int dataSize  = DATA_SIZE,
    parameter int cntWidth  = CNT_WIDTH,
    parameter int wSpadNReg = W_SPAD_NREG,
    parameter int aSpadNReg = A_SPAD_NREG
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                job_start,
    input  logic [cntWidth-1:0] cfg_wcount,
    input  logic [cntWidth-1:0] cfg_acount,
    input  logic [dataSize-1:0] w_data_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic [dataSize-1:0] a_data_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    output logic [dataSize-1:0] pe_weights_o,
    output logic [dataSize-1:0] pe_acts_o,
    output logic                pe_ctrl_loadw,
    output logic                pe_ctrl_loada,
    output logic                pe_ctrl_start,
    output logic                pe_ctrl_sums,
    output logic [cntWidth-1:0] pe_ctrl_wcount,
    output logic [cntWidth-1:0] pe_ctrl_acount,
    input  logic                pe_flag_done,
    output logic                job_busy,
    output logic                job_done,
    output logic                err_cfg
);

    localparam logic [cntWidth:0] W_MAX = wSpadNReg[cntWidth:0];
    localparam logic [cntWidth:0] A_MAX = aSpadNReg[cntWidth:0];

    pe_state_e state, nxt;

    logic                cfg_ok, accept, w_hs, a_hs;
    logic                ld_load, ld_dec, ld_zero;
    logic                sm_load, sm_dec, sm_zero;
    logic [cntWidth-1:0] ld_val, sm_val;

    assign cfg_ok = (cfg_wcount != '0) &&
                    ({1'b0, cfg_wcount} <= W_MAX) &&
                    ({1'b0, cfg_acount} <= A_MAX) &&
                    (cfg_acount >= cfg_wcount);
    assign accept = (state == ST_IDLE) && job_start && cfg_ok;
    assign w_hs   = w_valid_i && w_ready_o;
    assign a_hs   = a_valid_i && a_ready_o;

    // One counter serves both load phases; it is reloaded in the gap cycle.
    pe_ctrl_hscnt #(.W(cntWidth)) u_ld_cnt (
        .clk(clk), .nrst(nrst), .load(ld_load), .load_val(ld_val),
        .dec(ld_dec), .zero(ld_zero)
    );

    pe_ctrl_hscnt #(.W(cntWidth)) u_sm_cnt (
        .clk(clk), .nrst(nrst), .load(sm_load), .load_val(sm_val),
        .dec(sm_dec), .zero(sm_zero)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        ld_load = 1'b0;
        ld_val  = '0;
        ld_dec  = 1'b0;
        sm_load = 1'b0;
        sm_val  = '0;
        sm_dec  = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                nxt     = ST_LOADW;
                ld_load = 1'b1;
                ld_val  = cfg_wcount - 1'b1;
            end
            ST_LOADW: if (w_hs) begin
                if (ld_zero) nxt = ST_GAPW;
                else         ld_dec = 1'b1;
            end
            ST_GAPW: begin
                nxt     = ST_LOADA;
                ld_load = 1'b1;
                ld_val  = pe_ctrl_acount - 1'b1;
            end
            ST_LOADA: if (a_hs) begin
                if (ld_zero) nxt = ST_GAPA;
                else         ld_dec = 1'b1;
            end
            ST_GAPA:  nxt = ST_START;
            ST_START: nxt = ST_COMPUTE;
            ST_COMPUTE: if (pe_flag_done) begin
                // SUMS lasts acount-wcount+1 cycles: load the count minus one.
                nxt     = ST_SUMS;
                sm_load = 1'b1;
                sm_val  = pe_ctrl_acount - pe_ctrl_wcount;
            end
            ST_SUMS: begin
                if (sm_zero) nxt = ST_DONE;
                else         sm_dec = 1'b1;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            w_ready_o      <= 1'b0;
            a_ready_o      <= 1'b0;
            pe_weights_o   <= '0;
            pe_acts_o      <= '0;
            pe_ctrl_loadw  <= 1'b0;
            pe_ctrl_loada  <= 1'b0;
            pe_ctrl_start  <= 1'b0;
            pe_ctrl_sums   <= 1'b0;
            pe_ctrl_wcount <= '0;
            pe_ctrl_acount <= '0;
            job_busy       <= 1'b0;
            job_done       <= 1'b0;
            err_cfg        <= 1'b0;
        end else begin
            w_ready_o     <= (nxt == ST_LOADW);
            a_ready_o     <= (nxt == ST_LOADA);
            pe_ctrl_loadw <= w_hs;
            pe_ctrl_loada <= a_hs;
            if (w_hs) pe_weights_o <= w_data_i;
            if (a_hs) pe_acts_o    <= a_data_i;
            // Registered from the current state so a quiet cycle separates
            // the last activation load from the start pulse.
            pe_ctrl_start <= (state == ST_START);
            pe_ctrl_sums  <= (nxt == ST_SUMS);
            job_busy      <= (nxt != ST_IDLE);
            job_done      <= (nxt == ST_DONE);
            err_cfg       <= (state == ST_IDLE) && job_start && !cfg_ok;
            if (accept) begin
                pe_ctrl_wcount <= cfg_wcount;
                pe_ctrl_acount <= cfg_acount;
            end
        end
    end

endmodule

// File: tb/tb_pe_ctrl.sv
// Randomized scoreboard bench for pe_ctrl: stimulus pushes the expected PE
// load values and SUMS length, a monitor pops and compares as outputs appear.
module tb_pe_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       job_start = 1'b0;
    logic [7:0] cfg_wcount = '0, cfg_acount = '0;
    logic [7:0] w_data_i = '0, a_data_i = '0;
    logic       w_valid_i = 1'b0, a_valid_i = 1'b0;
    logic       w_ready_o, a_ready_o;
    logic [7:0] pe_weights_o, pe_acts_o, pe_ctrl_wcount, pe_ctrl_acount;
    logic       pe_ctrl_loadw, pe_ctrl_loada, pe_ctrl_start, pe_ctrl_sums;
    logic       job_busy, job_done, err_cfg;
    logic       done_model = 1'b0, done_inj = 1'b0;
    logic       pe_flag_done;

    assign pe_flag_done = done_model | done_inj;

    pe_ctrl dut (
        .clk(clk), .nrst(nrst), .job_start(job_start),
        .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount),
        .w_data_i(w_data_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .pe_weights_o(pe_weights_o), .pe_acts_o(pe_acts_o),
        .pe_ctrl_loadw(pe_ctrl_loadw), .pe_ctrl_loada(pe_ctrl_loada),
        .pe_ctrl_start(pe_ctrl_start), .pe_ctrl_sums(pe_ctrl_sums),
        .pe_ctrl_wcount(pe_ctrl_wcount), .pe_ctrl_acount(pe_ctrl_acount),
        .pe_flag_done(pe_flag_done), .job_busy(job_busy),
        .job_done(job_done), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int exp_w_q[$], exp_a_q[$], exp_sums_q[$], exp_tight_q[$];
    int src_w_q[$], src_a_q[$];
    int vmode = 0;
    int exp_err = 0, exp_done = 0;
    int err_seen = 0, done_seen = 0, ctrl_seen = 0;
    int la_in_job = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit valid_ok(input int mode, input bit tog);
        if (mode == 0) return 1'b1;
        if (mode == 1) return tog;
        return bit'($urandom_range(0, 1));
    endfunction

    // Stream sources: ready is stable between edges, so a handshake at the
    // coming rising edge is known at the falling edge before it.
    initial begin
        bit w_pend = 0, a_pend = 0, tog = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                w_valid_i = 0; a_valid_i = 0; w_pend = 0; a_pend = 0;
                continue;
            end
            if (w_pend && src_w_q.size() > 0) void'(src_w_q.pop_front());
            if (a_pend && src_a_q.size() > 0) void'(src_a_q.pop_front());
            tog = ~tog;
            w_valid_i = (src_w_q.size() > 0) && valid_ok(vmode, tog);
            w_data_i  = (src_w_q.size() > 0) ? src_w_q[0][7:0] : 8'h00;
            a_valid_i = (src_a_q.size() > 0) && valid_ok(vmode, tog);
            a_data_i  = (src_a_q.size() > 0) ? src_a_q[0][7:0] : 8'h00;
            w_pend = w_valid_i && w_ready_o;
            a_pend = a_valid_i && a_ready_o;
        end
    end

    // PE model: done 20 cycles after it sees start.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst && pe_ctrl_start) begin
                repeat (20) @(negedge clk);
                done_model = 1'b1;
                @(negedge clk);
                done_model = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int cyc = 0, sums_cnt = 0, start_cnt = 0;
        int last_lw = 0, first_la = -1, last_la = 0, start_cyc = 0;
        int tight;
        forever begin
            @(negedge clk);
            cyc++;
            if (!nrst) begin
                sums_cnt = 0; start_cnt = 0; first_la = -1; la_in_job = 0;
                continue;
            end
            if (pe_ctrl_loadw | pe_ctrl_loada | pe_ctrl_start | pe_ctrl_sums) ctrl_seen++;
            if (pe_ctrl_loadw) begin
                if (exp_w_q.size() == 0) check("loadw_extra", 1, 0);
                else check("loadw_data", pe_weights_o, exp_w_q.pop_front());
                last_lw = cyc;
            end
            if (pe_ctrl_loada) begin
                if (exp_a_q.size() == 0) check("loada_extra", 1, 0);
                else check("loada_data", pe_acts_o, exp_a_q.pop_front());
                if (first_la < 0) first_la = cyc;
                last_la = cyc;
                la_in_job++;
            end
            if (pe_ctrl_start) begin start_cnt++; start_cyc = cyc; end
            if (pe_ctrl_sums) sums_cnt++;
            if (err_cfg) err_seen++;
            if (job_done) begin
                done_seen++;
                if (exp_sums_q.size() == 0) check("done_extra", 1, 0);
                else begin
                    check("sums_cycles", sums_cnt, exp_sums_q.pop_front());
                    check("start_pulses", start_cnt, 1);
                    check("w_left", exp_w_q.size(), 0);
                    check("a_left", exp_a_q.size(), 0);
                    tight = exp_tight_q.pop_front();
                    if (tight != 0) begin
                        check("gap_w_to_a", first_la - last_lw, 2);
                        check("gap_a_to_start", start_cyc - last_la, 2);
                    end
                end
                sums_cnt = 0; start_cnt = 0; first_la = -1; la_in_job = 0;
            end
        end
    end

    task automatic start_job(input int w, input int a, input int mode, input bit tight, output bit ok);
        ok = (w != 0) && (w <= 16) && (a <= 16) && (a >= w);
        @(negedge clk);
        vmode = mode;
        if (ok) begin
            for (int i = 0; i < w; i++) begin
                int v = int'($urandom_range(0, 255));
                exp_w_q.push_back(v); src_w_q.push_back(v);
            end
            for (int i = 0; i < a; i++) begin
                int v = int'($urandom_range(0, 255));
                exp_a_q.push_back(v); src_a_q.push_back(v);
            end
            exp_sums_q.push_back(a + 1 - w);
            exp_tight_q.push_back(int'(tight));
        end else exp_err++;
        cfg_wcount = w[7:0];
        cfg_acount = a[7:0];
        job_start  = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        if (ok) begin
            check("busy_level", job_busy, 1);
            check("w_ready_latency", w_ready_o, 1);
        end
    endtask

    task automatic run_job(input int w, input int a, input int mode, input bit tight,
                           input bit inj_lw, input bit inj_cmp, input bit inj_done);
        bit ok, seen;
        int sc;
        start_job(w, a, mode, tight, ok);
        if (!ok) begin
            repeat (3) @(negedge clk);
            check("busy_after_err", job_busy, 0);
            return;
        end
        if (inj_lw) begin
            done_inj = 1'b1;
            @(negedge clk);
            done_inj = 1'b0;
        end
        seen = 0;
        sc = -1;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            job_start = 1'b0;
            if (inj_cmp && pe_ctrl_start) sc = 0;
            else if (sc >= 0) sc++;
            if (sc == 3) begin
                cfg_wcount = 8'd2; cfg_acount = 8'd2; job_start = 1'b1;
            end
            if (job_done) begin
                seen = 1;
                if (inj_done) begin
                    cfg_wcount = 8'd1; cfg_acount = 8'd1; job_start = 1'b1;
                end
            end
        end
        if (!seen) check("job_done_timeout", 0, 1);
        else exp_done++;
        @(negedge clk);
        job_start = 1'b0;
        check("idle_after_done", job_busy, 0);
    endtask

    initial begin
        bit ok;
        int ctrl0, w, a;
        #3 nrst = 1'b0;
        #1;
        check("rst_data", {pe_weights_o, pe_acts_o, pe_ctrl_wcount, pe_ctrl_acount}, 0);
        check("rst_ctrl", {job_busy, job_done, err_cfg, w_ready_o, a_ready_o,
                           pe_ctrl_loadw, pe_ctrl_loada, pe_ctrl_start, pe_ctrl_sums}, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        run_job(3, 16, 0, 1, 0, 0, 0);
        run_job(3, 16, 1, 0, 0, 0, 0);

        ctrl0 = ctrl_seen;
        run_job(0, 5, 0, 0, 0, 0, 0);
        run_job(4, 2, 0, 0, 0, 0, 0);
        run_job(4, 17, 0, 0, 0, 0, 0);
        check("err_pulses", err_seen, exp_err);
        check("no_ctrl_on_err", ctrl_seen - ctrl0, 0);

        run_job(16, 16, 0, 1, 0, 0, 0);
        run_job(1, 1, 2, 0, 0, 0, 0);
        run_job(3, 8, 0, 1, 1, 1, 1);
        for (int k = 0; k < 6; k++) begin
            w = int'($urandom_range(1, 16));
            a = int'($urandom_range(w, 16));
            run_job(w, a, 2, 0, 0, 0, 0);
        end

        // Reset in the middle of the activation phase.
        start_job(4, 10, 0, 0, ok);
        for (int t = 0; t < 500 && la_in_job < 5; t++) @(negedge clk);
        check("reached_loada", la_in_job >= 5, 1);
        #2 nrst = 1'b0;
        #1;
        check("midrst_data", {pe_weights_o, pe_acts_o, pe_ctrl_wcount, pe_ctrl_acount}, 0);
        check("midrst_ctrl", {job_busy, job_done, err_cfg, w_ready_o, a_ready_o,
                              pe_ctrl_loadw, pe_ctrl_loada, pe_ctrl_start, pe_ctrl_sums}, 0);
        exp_w_q.delete(); exp_a_q.delete(); exp_sums_q.delete(); exp_tight_q.delete();
        src_w_q.delete(); src_a_q.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        run_job(4, 10, 0, 1, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("done_count", done_seen, exp_done);
        check("err_total", err_seen, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 SHALL have parameters: dataSize, default 8, data width; cntWidth, default 8, count width; wSpadNReg, default 16, max weights; aSpadNReg, default 16, max activations.
REQ-002 SHALL have port clk, input, 1, single clock; all logic samples on the rising edge.
REQ-003 SHALL have port nrst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port job_start, input, 1, one-cycle job request.
REQ-005 SHALL have ports cfg_wcount and cfg_acount, input, cntWidth each, weight and activation counts for the job.
REQ-006 SHALL have ports w_data_i (input, dataSize), w_valid_i (input, 1) and w_ready_o (output, 1), forming the weight stream.
REQ-007 SHALL have ports a_data_i (input, dataSize), a_valid_i (input, 1) and a_ready_o (output, 1), forming the activation stream.
REQ-008 SHALL have ports pe_weights_o and pe_acts_o, output, dataSize each, PE data drive.
REQ-009 SHALL have ports pe_ctrl_loadw, pe_ctrl_loada, pe_ctrl_start and pe_ctrl_sums, output, 1 each, PE controls.
REQ-010 SHALL have ports pe_ctrl_wcount and pe_ctrl_acount, output, cntWidth each, latched job counts.
REQ-011 SHALL have port pe_flag_done, input, 1, PE compute complete.
REQ-012 SHALL have ports job_busy, job_done and err_cfg, output, 1 each: busy level, done pulse, config-error pulse.

Function
REQ-013 SHALL implement FSM states IDLE, LOADW, GAPW, LOADA, GAPA, START, COMPUTE, SUMS, DONE.
REQ-014 In IDLE, job_start=1 with valid config SHALL latch cfg_wcount/cfg_acount into pe_ctrl_wcount/pe_ctrl_acount and go to LOADW; job_start outside IDLE SHALL be ignored.
REQ-015 Config SHALL be invalid when wcount=0, wcount>wSpadNReg, acount>aSpadNReg or acount<wcount; invalid job_start SHALL pulse err_cfg one cycle (registered) and remain in IDLE.
REQ-016 w_ready_o SHALL be 1 only in LOADW; each w_valid_i&&w_ready_o handshake SHALL, next cycle, drive pe_weights_o=w_data_i with pe_ctrl_loadw=1; non-handshake cycles SHALL drive pe_ctrl_loadw=0 (bubbles allowed).
REQ-017 After wcount handshakes, w_ready_o SHALL drop in the same cycle as the last handshake's registered output appears; FSM passes one GAPW cycle (all loads 0) then LOADA.
REQ-018 LOADA/GAPA SHALL mirror REQ-016/017 with a_* ports, pe_acts_o, pe_ctrl_loada and acount.
REQ-019 START SHALL assert pe_ctrl_start for exactly one cycle, then enter COMPUTE.
REQ-020 COMPUTE SHALL wait for pe_flag_done=1; pe_flag_done in any other state SHALL be ignored.
REQ-021 SUMS SHALL hold pe_ctrl_sums=1 for exactly acount+1-wcount cycles, counted by a cntWidth down-counter, then go to DONE.
REQ-022 DONE SHALL pulse job_done one cycle and return to IDLE; job_start in that DONE cycle SHALL be ignored.
REQ-023 job_busy SHALL be 1 in all states except IDLE.
REQ-024 All outputs SHALL be registered; job_start-to-w_ready_o latency SHALL be 1 cycle.
REQ-025 Boundary acount=wcount SHALL give exactly 1 SUMS cycle; wcount=wSpadNReg with acount=aSpadNReg SHALL be accepted.

Reset
REQ-026 nrst=0 SHALL asynchronously force IDLE and all outputs and counters to 0, including mid-job; the PE is re-sequenced from a fresh job_start.

Structure
REQ-027 Shared package pe_pkg SHALL hold the state enum, dataSize/cntWidth defaults and spad depth constants used by PE and pe_ctrl.
REQ-028 A sub-module pe_ctrl_hscnt SHALL implement load/decrement/zero-flag counting, instanced for the load and SUMS phases.

Verification
REQ-029 wcount=3, acount=16, streams always valid, PE model done 20 cycles after start -> 3 loadw cycles, 1 gap, 16 loada cycles, 1 gap, 1 start, 14 sums cycles, one job_done pulse.
REQ-030 Same job with w_valid_i toggled every other cycle -> exactly 3 loadw pulses carrying streamed values in order; no loss or duplication.
REQ-031 job_start with wcount=0, then wcount=4 with acount=2, then acount=17 -> three err_cfg pulses, job_busy stays 0, no PE controls asserted.
REQ-032 wcount=acount=16 -> accepted, exactly 1 sums cycle.
REQ-033 nrst low during LOADA after 5 activations -> all outputs 0 immediately; a new job then completes normally.
REQ-034 job_start pulsed during COMPUTE and pe_flag_done pulsed during LOADW -> both ignored, sequence unchanged.
